// File: rtl/rr_mux_n.sv
// Registered N:1 mux with its own round-robin / fixed-priority arbiter; 1 clock from handshake to out_valid.
// Backpressure: in_ready is held low while the output register is full and out_ready is low.
module rr_mux_n #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic            load_en;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] ptr;
  int unsigned     scan_idx;

  assign load_en = !out_valid || out_ready;

  // Scan from highest to lowest rank so the last hit is the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mode) begin
        scan_idx = k;
      end else begin
        scan_idx = (int'(ptr) + k) % N;
      end
      if (in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = SELW'(scan_idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load_en && grant_vld && (grant_idx == SELW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
        out_sel   <= grant_idx;
        if (!mode) begin
          ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Scoreboard bench for rr_mux_n: a reference arbiter predicts each grant and queues the expected word.
module tb_rr_mux_n;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     out_sel;
  logic           out_ready;

  always #5 clk = ~clk;

  rr_mux_n #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] dat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   ptr_m;
  bit   mv_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input bit m, input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = m ? k : (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Inputs are set just after a rising edge; checks run on the falling edge.
  task automatic step();
    int             w;
    logic [N-1:0]   er;
    bit             le;
    exp_t           e;
    @(negedge clk);
    le = !mv_m || out_ready;
    w  = arb(mode, in_valid, ptr_m);
    er = '0;
    if (!rst && le && w >= 0) er[w] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, mv_m);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.dat);
        chk("out_sel", out_sel, e.sel);
      end
    end
    if (rst) begin
      mv_m  = 1'b0;
      ptr_m = 0;
      sb.delete();
    end else if (le) begin
      if (w >= 0) begin
        e.sel = 2'(w);
        e.dat = in_data[w*W +: W];
        sb.push_back(e);
        mv_m = 1'b1;
        if (!mode) ptr_m = (w + 1) % N;
      end else begin
        mv_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    mv_m      = 1'b0;
    ptr_m     = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", out_valid, 0);
    chk("init_data", out_data, 0);
    chk("init_sel", out_sel, 0);
    chk("init_rdy", in_ready, 0);
    rst = 1'b0;
    step();
    step();

    // round-robin with all channels requesting
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    chk("rr_first_sel", out_sel, 0);
    repeat (8) step();

    // fixed priority
    mode     = 1'b1;
    in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    in_valid = 4'b1010;
    repeat (4) step();
    chk("fp_sel1", out_sel, 1);
    chk("fp_data1", out_data, 8'hB1);
    in_valid = 4'b1000;
    repeat (2) step();
    chk("fp_sel3", out_sel, 3);

    // backpressure then simultaneous consume/load
    out_ready            = 1'b0;
    in_valid             = 4'b0100;
    in_data[2*W +: W]    = 8'hC2;
    repeat (3) begin
      step();
      chk("stall_data", out_data, 8'hB3);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'hC2);
    chk("bp_sel", out_sel, 2);

    // pointer wrap and skip
    mode     = 1'b0;
    in_valid = 4'b0100;
    step();
    in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    in_valid = 4'b0011;
    step();
    chk("wrap_sel0", out_sel, 0);
    step();
    chk("wrap_sel1", out_sel, 1);
    in_valid = 4'b1111;
    step();
    chk("wrap_ptr2", out_sel, 2);

    // drain
    in_valid = 4'b0000;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_data", out_data, 8'hD2);
    chk("drain_sel", out_sel, 2);
    step();

    // random traffic
    repeat (300) begin
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      step();
    end

    // asynchronous reset mid-transfer
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #1;
    rst   = 1'b1;
    mv_m  = 1'b0;
    ptr_m = 0;
    sb.delete();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rdy", in_ready, 0);
    step();
    rst      = 1'b0;
    in_valid = 4'b0000;
    step();
    step();
    chk("post_rst_idle", out_valid, 0);
    in_valid = 4'b1111;
    step();
    chk("post_rst_sel", out_sel, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer. Selects between N channels using its own arbiter, replacing the single external select line of the basic 2:1 mux.
- Each input channel and the output use a valid/ready handshake. The result is held in a single output register.
- Supports two arbitration modes: round-robin (fair) and fixed priority.
- Sits between N producer channels and one consumer in the datapath.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, data width per channel.
- SELW, $clog2(N), width of the channel index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational, one-hot or zero.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - out_valid = 0, out_data = 0, out_sel = 0, round-robin pointer ptr = 0.
  - in_ready = 0 while rst is high.
- Load enable: load_en = !out_valid | out_ready. It is combinational and allows full throughput with no bubble.
- Arbitration (combinational, evaluated only when load_en = 1 and |in_valid = 1):
  - mode = 1: the winner is the lowest index i with in_valid[i] = 1.
  - mode = 0: the winner is the first index with in_valid set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - in_ready[winner] = 1; all other in_ready bits = 0.
  - When load_en = 0 or no input is valid, in_ready = 0.
- Transfer on an input: happens on a clock edge where in_valid[i] & in_ready[i]. At that edge:
  - out_data <= channel i data, out_sel <= i, out_valid <= 1.
  - If mode = 0: ptr <= (i == N-1) ? 0 : i+1.
  - If mode = 1: ptr is unchanged.
- Output drain with no new input: if load_en = 1 and no input is valid, out_valid <= 0 on the clock edge. out_data and out_sel hold their last values.
- Stall: if out_valid = 1 and out_ready = 0, then out_data, out_sel and ptr hold, and in_ready = 0.
- Simultaneous consume and load: when out_valid & out_ready and some input is valid in the same cycle, the old word is consumed and the new word is loaded on the same edge. out_valid stays 1.
- Latency: 1 clock from input handshake to out_valid.
- Mode change: may occur on any cycle and takes effect in the arbitration of that same cycle. ptr is preserved, so round-robin resumes from the stored pointer.
- Input data rule: producers must hold in_data and in_valid until handshake; the block does not check this.
- Reset mid-transfer: any pending out_data is discarded and no handshake is generated in the reset cycle.
- No combinational path from in_data to out_data. Combinational paths exist from out_ready/in_valid/mode to in_ready.

Test Plan:
- Reset/idle: assert rst mid-run with out_valid = 1 -> out_valid = 0, out_sel = 0, in_ready = 4'b0000 immediately, without waiting for a clock edge. After release with in_valid = 0 -> out_valid stays 0.
- Round-robin fairness: mode = 0, in_valid = 4'b1111, out_ready = 1, data ch0..3 = 8'hA0, 8'hA1, 8'hA2, 8'hA3 -> out_sel sequence 0,1,2,3,0,... and out_data A0,A1,A2,A3,A0. in_ready is one-hot, one transfer per cycle.
- Fixed priority: mode = 1, in_valid = 4'b1010 held, out_ready = 1 -> every transfer is from channel 1 (out_data = ch1 data). Then drop in_valid[1] -> channel 3 wins.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with in_valid = 4'b0100 -> in_ready = 0 and out_data held. Raise out_ready -> ch2 loads on the same edge the old word is consumed, and out_valid stays 1.
- Pointer wrap/skip: mode = 0, ptr = 3 (after a ch2 grant), in_valid = 4'b0011 -> winner 0, then winner 1, then ptr = 2.
- Drain: out_valid = 1, out_ready = 1, in_valid = 0 -> out_valid = 0 on the next edge, and out_data keeps its previous value.
